// File: rtl/regdump_uart_tx.sv
// regdump_uart_tx
//   Dumps a contiguous (wrapping) range of 32-bit registers out of a UART
//   transmitter, 8N1, most-significant byte of each register first.
//
//   Optional feature macro: REGDUMP_HDR_EN
//     defined   -> each register is preceded by a header byte {4'hA, addr}
//     undefined -> 4 data bytes per register, no header
//
//   Ports
//     clk         rising-edge system clock
//     rst         asynchronous, active-high reset
//     start       dump request, sampled on clk (ignored while a dump runs)
//     first_addr  first register to dump
//     last_addr   last register to dump (wraps 15 -> 0 when below first_addr)
//     rd_addr     register bank read address, {1'b0, current address}
//     rd_data     register bank combinational read data for rd_addr
//     tx          UART serial line, idle high
//     busy        high while a dump is in progress
//     done        one-cycle pulse when a dump completes
module regdump_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  first_addr,
  input  logic [3:0]  last_addr,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] BIT_CNT_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef REGDUMP_HDR_EN
  localparam logic [2:0]  BYTE_LAST    = 3'd4;
`else
  localparam logic [2:0]  BYTE_LAST    = 3'd3;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_addr, w_addr_nxt;
  logic [3:0]  r_last, w_last_nxt;
  logic [31:0] r_hold, w_hold_nxt;
  logic [2:0]  r_byte_idx, w_byte_nxt;
  logic [3:0]  r_bit_idx, w_bit_nxt;
  logic [15:0] r_clk_cnt, w_cnt_nxt;
  logic [7:0]  w_byte_val;
  logic        w_tx_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_rd_addr;

  // Line level of one 8N1 frame position: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    case (idx)
      4'd0:    frame_bit = 1'b0;
      4'd1:    frame_bit = data[0];
      4'd2:    frame_bit = data[1];
      4'd3:    frame_bit = data[2];
      4'd4:    frame_bit = data[3];
      4'd5:    frame_bit = data[4];
      4'd6:    frame_bit = data[5];
      4'd7:    frame_bit = data[6];
      4'd8:    frame_bit = data[7];
      default: frame_bit = 1'b1;
    endcase
  endfunction

  // Next-state, datapath and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_byte_nxt  = r_byte_idx;
    w_bit_nxt   = r_bit_idx;
    w_cnt_nxt   = r_clk_cnt;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = LOAD;
          w_addr_nxt  = first_addr;
          w_last_nxt  = last_addr;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        // rd_addr has been stable for a full cycle; take the snapshot.
        w_hold_nxt  = rd_data;
        w_byte_nxt  = 3'd0;
        w_bit_nxt   = 4'd0;
        w_cnt_nxt   = 16'd0;
        w_state_nxt = SEND;
      end
      SEND: begin
        if (r_clk_cnt == BIT_CNT_LAST) begin
          w_cnt_nxt = 16'd0;
          if (r_bit_idx == 4'd9) begin
            w_bit_nxt = 4'd0;
            if (r_byte_idx == BYTE_LAST) begin
              w_byte_nxt = 3'd0;
              if (r_addr == r_last) begin
                w_state_nxt = FINISH;
              end else begin
                w_addr_nxt  = r_addr + 4'd1;
                w_state_nxt = LOAD;
              end
            end else begin
              w_byte_nxt = r_byte_idx + 3'd1;
            end
          end else begin
            w_bit_nxt = r_bit_idx + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Byte that will be on the line after this edge.
    case (w_byte_nxt)
`ifdef REGDUMP_HDR_EN
      3'd0:    w_byte_val = {4'hA, w_addr_nxt};
      3'd1:    w_byte_val = w_hold_nxt[31:24];
      3'd2:    w_byte_val = w_hold_nxt[23:16];
      3'd3:    w_byte_val = w_hold_nxt[15:8];
      3'd4:    w_byte_val = w_hold_nxt[7:0];
`else
      3'd0:    w_byte_val = w_hold_nxt[31:24];
      3'd1:    w_byte_val = w_hold_nxt[23:16];
      3'd2:    w_byte_val = w_hold_nxt[15:8];
      3'd3:    w_byte_val = w_hold_nxt[7:0];
`endif
      default: w_byte_val = 8'hFF;
    endcase

    if (w_state_nxt == SEND) begin
      w_tx_nxt = frame_bit(w_byte_val, w_bit_nxt);
    end else begin
      w_tx_nxt = 1'b1;
    end
    w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == SEND);
    w_done_nxt = (w_state_nxt == FINISH);
  end

  // State, datapath and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= 4'd0;
      r_last     <= 4'd0;
      r_hold     <= 32'd0;
      r_byte_idx <= 3'd0;
      r_bit_idx  <= 4'd0;
      r_clk_cnt  <= 16'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_addr  <= 5'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_last     <= w_last_nxt;
      r_hold     <= w_hold_nxt;
      r_byte_idx <= w_byte_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_clk_cnt  <= w_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_rd_addr  <= {1'b0, w_addr_nxt};
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_addr = r_rd_addr;

endmodule

// File: tb/tb_regdump_uart_tx.sv
// Directed testbench for regdump_uart_tx with CLKS_PER_BIT = 4.
// The tx line is captured once per cycle and decoded by a small 8N1
// receiver; bytes, start-bit positions, busy length, done pulses and the
// rd_addr sequence are compared against hand-derived expectations.
// Follows REGDUMP_HDR_EN for the expected byte stream.
module tb_regdump_uart_tx;

  localparam int CPB = 4;
`ifdef REGDUMP_HDR_EN
  localparam int BPR = 5;
`else
  localparam int BPR = 4;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  first_addr;
  logic [3:0]  last_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] regs [16];
  logic        ovr;

  int vec_cnt;
  int err_cnt;

  // capture results
  logic        cap_tx [4096];
  int          cap_n;
  int          cap_busy;
  int          cap_done;
  int          cap_busy_after;
  int          frame_err;
  logic [7:0]  rx_bytes [$];
  int          rx_start [$];
  logic [4:0]  addr_seq [$];

  // expectations
  logic [7:0]  exp_bytes [$];
  int          exp_start [$];
  logic [4:0]  exp_addr [$];
  int          exp_busy;
  int          exp_pos;

  regdump_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  assign rd_data = ovr ? 32'hFFFF_FFFF : regs[rd_addr[3:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp_clear();
    exp_bytes.delete();
    exp_start.delete();
    exp_addr.delete();
    exp_busy = 0;
    exp_pos  = 0;
  endtask

  // One register: a LOAD cycle, then BPR back-to-back 10-bit frames.
  task automatic exp_reg(input logic [3:0] a, input logic [31:0] v);
    logic [7:0] hdr;
    hdr = {4'hA, a};
    exp_addr.push_back({1'b0, a});
    exp_pos  = exp_pos + 1;
    exp_busy = exp_busy + 1 + BPR * 10 * CPB;
    if (BPR == 5) begin
      exp_bytes.push_back(hdr);
      exp_start.push_back(exp_pos);
      exp_pos = exp_pos + 10 * CPB;
    end
    for (int k = 3; k >= 0; k--) begin
      exp_bytes.push_back(v[k*8 +: 8]);
      exp_start.push_back(exp_pos);
      exp_pos = exp_pos + 10 * CPB;
    end
  endtask

  // Pulse start, record the line every cycle until done, then decode.
  task automatic run_dump(input logic [3:0] f, input logic [3:0] l,
                          input int restart_at, input int ovr_at);
    int i;
    logic seen_done;
    logic [7:0] b;
    first_addr = f;
    last_addr  = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cap_n = 0; cap_busy = 0; cap_done = 0; cap_busy_after = 0;
    seen_done = 1'b0;
    addr_seq.delete();
    while (!seen_done && cap_n < 4000) begin
      start = (cap_n == restart_at);
      if (cap_n == ovr_at) ovr = 1'b1;
      cap_tx[cap_n] = tx;
      if (busy) begin
        cap_busy++;
        if (addr_seq.size() == 0 || addr_seq[$] != rd_addr) addr_seq.push_back(rd_addr);
      end
      if (done) begin
        cap_done++;
        seen_done = 1'b1;
        if (restart_at >= 0) start = 1'b1;
      end
      cap_n++;
      @(negedge clk);
    end
    start = 1'b0;
    ovr   = 1'b0;
    repeat (20) begin
      if (done) cap_done++;
      if (busy) cap_busy_after++;
      @(negedge clk);
    end
    rx_bytes.delete();
    rx_start.delete();
    frame_err = 0;
    i = 0;
    while (i < cap_n) begin
      if (cap_tx[i] == 1'b0 && i + 10 * CPB - 1 < cap_n) begin
        for (int k = 0; k < 8; k++) b[k] = cap_tx[i + CPB * (k + 1) + CPB / 2];
        if (cap_tx[i + CPB / 2] != 1'b0 || cap_tx[i + 9 * CPB + CPB / 2] != 1'b1) frame_err++;
        rx_bytes.push_back(b);
        rx_start.push_back(i);
        i = i + 10 * CPB;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; ovr = 1'b0;
    first_addr = 4'd5; last_addr = 4'd6;
    repeat (3) @(negedge clk);
    vec_cnt++; if (tx !== 1'b1) begin err_cnt++; $display("FAIL reset_tx got %b want 1", tx); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", done); end
    vec_cnt++; if (rd_addr !== 5'd0) begin err_cnt++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (busy !== 1'b0 || tx !== 1'b1) begin err_cnt++; $display("FAIL post_reset_idle got busy=%b tx=%b want busy=0 tx=1", busy, tx); end
  endtask

  task automatic test_single();
    regs[3] = 32'h1234_5678;
    exp_clear();
    exp_reg(4'd3, 32'h1234_5678);
    run_dump(4'd3, 4'd3, -1, -1);
    vec_cnt++; if (rx_bytes.size() != exp_bytes.size()) begin err_cnt++; $display("FAIL single_nbytes got %0d want %0d", rx_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      vec_cnt++; if (rx_bytes[i] !== exp_bytes[i]) begin err_cnt++; $display("FAIL single_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]); end
      vec_cnt++; if (rx_start[i] != exp_start[i]) begin err_cnt++; $display("FAIL single_start%0d got %0d want %0d", i, rx_start[i], exp_start[i]); end
    end
    vec_cnt++; if (frame_err != 0) begin err_cnt++; $display("FAIL single_framing got %0d errors want 0", frame_err); end
    vec_cnt++; if (cap_busy != BPR * 40 + 1) begin err_cnt++; $display("FAIL single_busy_len got %0d want %0d", cap_busy, BPR * 40 + 1); end
    vec_cnt++; if (cap_done != 1) begin err_cnt++; $display("FAIL single_done_cnt got %0d want 1", cap_done); end
    vec_cnt++; if (addr_seq.size() != 1 || addr_seq[0] !== 5'd3) begin err_cnt++; $display("FAIL single_rd_addr got n=%0d first=%0d want n=1 first=3", addr_seq.size(), addr_seq[0]); end
  endtask

  task automatic test_wrap();
    regs[14] = 32'h0000_000E; regs[15] = 32'h0000_000F;
    regs[0]  = 32'h0000_0000; regs[1]  = 32'h0000_0001;
    exp_clear();
    exp_reg(4'd14, 32'h0000_000E);
    exp_reg(4'd15, 32'h0000_000F);
    exp_reg(4'd0,  32'h0000_0000);
    exp_reg(4'd1,  32'h0000_0001);
    run_dump(4'd14, 4'd1, -1, -1);
    vec_cnt++; if (rx_bytes.size() != exp_bytes.size()) begin err_cnt++; $display("FAIL wrap_nbytes got %0d want %0d", rx_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      vec_cnt++; if (rx_bytes[i] !== exp_bytes[i] || rx_start[i] != exp_start[i]) begin
        err_cnt++; $display("FAIL wrap_byte%0d got %h@%0d want %h@%0d", i, rx_bytes[i], rx_start[i], exp_bytes[i], exp_start[i]);
      end
    end
    vec_cnt++; if (addr_seq.size() != exp_addr.size()) begin err_cnt++; $display("FAIL wrap_naddr got %0d want %0d", addr_seq.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < addr_seq.size(); i++) begin
      vec_cnt++; if (addr_seq[i] !== exp_addr[i]) begin err_cnt++; $display("FAIL wrap_rd_addr%0d got %0d want %0d", i, addr_seq[i], exp_addr[i]); end
    end
    vec_cnt++; if (cap_busy != exp_busy) begin err_cnt++; $display("FAIL wrap_busy_len got %0d want %0d", cap_busy, exp_busy); end
    vec_cnt++; if (cap_done != 1) begin err_cnt++; $display("FAIL wrap_done_cnt got %0d want 1", cap_done); end
  endtask

  // start re-pulsed mid second byte and again during FINISH.
  task automatic test_restart();
    regs[3] = 32'h1234_5678;
    exp_clear();
    exp_reg(4'd3, 32'h1234_5678);
    run_dump(4'd3, 4'd3, 60, -1);
    vec_cnt++; if (rx_bytes.size() != exp_bytes.size()) begin err_cnt++; $display("FAIL restart_nbytes got %0d want %0d", rx_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      vec_cnt++; if (rx_bytes[i] !== exp_bytes[i] || rx_start[i] != exp_start[i]) begin
        err_cnt++; $display("FAIL restart_byte%0d got %h@%0d want %h@%0d", i, rx_bytes[i], rx_start[i], exp_bytes[i], exp_start[i]);
      end
    end
    vec_cnt++; if (cap_busy != exp_busy) begin err_cnt++; $display("FAIL restart_busy_len got %0d want %0d", cap_busy, exp_busy); end
    vec_cnt++; if (cap_done != 1) begin err_cnt++; $display("FAIL restart_done_cnt got %0d want 1", cap_done); end
    vec_cnt++; if (cap_busy_after != 0) begin err_cnt++; $display("FAIL restart_in_finish got busy_cycles=%0d want 0", cap_busy_after); end
  endtask

  task automatic test_snapshot();
    regs[3] = 32'h1234_5678;
    exp_clear();
    exp_reg(4'd3, 32'h1234_5678);
    run_dump(4'd3, 4'd3, -1, 1);
    vec_cnt++; if (rx_bytes.size() != exp_bytes.size()) begin err_cnt++; $display("FAIL snap_nbytes got %0d want %0d", rx_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      vec_cnt++; if (rx_bytes[i] !== exp_bytes[i]) begin err_cnt++; $display("FAIL snap_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    regs[3] = 32'h1234_5678;
    first_addr = 4'd3; last_addr = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // sample 46: first data bit of the second byte, which is 0
    repeat (46) @(negedge clk);
    vec_cnt++; if (tx !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL mid_pre_reset got tx=%b busy=%b want tx=0 busy=1", tx, busy); end
    #2 rst = 1'b1;
    #1;
    vec_cnt++; if (tx !== 1'b1) begin err_cnt++; $display("FAIL mid_reset_tx got %b want 1", tx); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_busy got %b want 0", busy); end
    vec_cnt++; if (rd_addr !== 5'd0) begin err_cnt++; $display("FAIL mid_reset_rd_addr got %0d want 0", rd_addr); end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    vec_cnt++; if (done_seen != 0) begin err_cnt++; $display("FAIL mid_reset_no_done got %0d pulses want 0", done_seen); end
    exp_clear();
    exp_reg(4'd3, 32'h1234_5678);
    run_dump(4'd3, 4'd3, -1, -1);
    vec_cnt++; if (rx_bytes.size() != exp_bytes.size()) begin err_cnt++; $display("FAIL after_reset_nbytes got %0d want %0d", rx_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      vec_cnt++; if (rx_bytes[i] !== exp_bytes[i]) begin err_cnt++; $display("FAIL after_reset_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]); end
    end
    vec_cnt++; if (cap_done != 1) begin err_cnt++; $display("FAIL after_reset_done_cnt got %0d want 1", cap_done); end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    test_reset();
    test_single();
    test_wrap();
    test_restart();
    test_snapshot();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/regdump_uart_tx.md
REGDUMP_UART_TX -- requirements
Module: regdump_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, the number of clk cycles per UART bit time (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: dump request, sampled on clk.
REQ-005 The block SHALL have port first_addr, input, 4 bits: first register to dump.
REQ-006 The block SHALL have port last_addr, input, 4 bits: last register to dump.
REQ-007 The block SHALL have port rd_addr, output, 5 bits: register bank read address, driven as {1'b0, current address}.
REQ-008 The block SHALL have port rd_data, input, 32 bits: register bank combinational read data for rd_addr.
REQ-009 The block SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a dump is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a dump completes.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, SEND and FINISH.
REQ-013 In IDLE, start=1 at edge k SHALL latch first_addr and last_addr, drive rd_addr={0,first_addr} and busy=1 after edge k, and enter LOAD.
REQ-014 In LOAD, the block SHALL snapshot rd_data into a 32-bit hold register at the next edge and enter SEND; tx SHALL go low (start bit) after that same edge.
REQ-015 Later changes to rd_data SHALL NOT affect bytes already snapshotted.
REQ-016 In SEND, each byte SHALL be sent 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit held exactly CLKS_PER_BIT cycles; a byte therefore takes 10*CLKS_PER_BIT cycles.
REQ-017 The data bytes of a register SHALL be sent most-significant byte first: [31:24], [23:16], [15:8], [7:0].
REQ-018 Consecutive bytes SHALL be sent back-to-back with no idle time between one stop bit and the next start bit.
REQ-019 After the last stop bit of a register: if the current address equals the latched last_addr, the block SHALL enter FINISH; otherwise it SHALL increment the address modulo 16 and enter LOAD.
REQ-020 When last_addr < first_addr, the address SHALL wrap 15 -> 0; first_addr == last_addr SHALL dump exactly one register.
REQ-021 In FINISH, the block SHALL assert done for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-022 start SHALL be ignored while busy=1 or while in FINISH.
REQ-023 tx SHALL be high in every state except during start and data bits.

Reset
REQ-024 While rst=1, the block SHALL hold state IDLE, tx=1, busy=0, done=0, rd_addr=0, the hold register at 0 and all counters at 0, independent of clk.
REQ-025 Reset asserted mid-byte SHALL abort the frame immediately with tx=1, and SHALL NOT produce a done pulse.

Configuration
REQ-026 With macro REGDUMP_HDR_EN defined, each register SHALL be preceded by a header byte {4'hA, addr[3:0]}, giving 5 bytes per register.
REQ-027 With REGDUMP_HDR_EN undefined, no header byte SHALL be sent, giving 4 bytes per register; all other behaviour SHALL be identical.

Verification
REQ-028 CLKS_PER_BIT=4, no HDR, R3=0x12345678, first=last=3, start pulse -> tx carries 0x12, 0x34, 0x56, 0x78 (LSB first, 8N1); busy high for 161 cycles; exactly one done pulse.
REQ-029 REGDUMP_HDR_EN defined, same stimulus -> tx carries 0xA3, 0x12, 0x34, 0x56, 0x78; busy high for 201 cycles.
REQ-030 first=14, last=1, R14..R1 = 0xE, 0xF, 0x0, 0x1 -> rd_addr sequence 14, 15, 0, 1; 16 bytes sent; busy ends after the fourth register.
REQ-031 start re-pulsed in the middle of the second byte -> no restart, byte stream unchanged, one done pulse total.
REQ-032 rd_data changed from 0x12345678 to 0xFFFFFFFF one cycle after LOAD -> tx still sends 0x12, 0x34, 0x56, 0x78.
REQ-033 rst asserted mid data bit of the second byte -> tx=1, busy=0, rd_addr=0 in the same cycle; no done pulse; a following start dumps normally.
